// File: rtl/rv_pkg.sv
// Shared constants and types for the multicycle RV32I datapath: opcodes,
// FSM states and the ALU operation encoding.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT
    } alu_op_t;

    // funct3 selects the operation; sub distinguishes SUB from ADD (R-type only).
    function automatic alu_op_t funct_op(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  funct_op = sub ? ALU_SUB : ALU_ADD;
            3'b010:  funct_op = ALU_SLT;
            3'b100:  funct_op = ALU_XOR;
            3'b110:  funct_op = ALU_OR;
            3'b111:  funct_op = ALU_AND;
            default: funct_op = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/rv_alu.sv
// Combinational integer ALU; zero flags an all-zero result for branch compares.
module rv_alu
    import rv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  alu_op_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle RV32I subset core: FETCH/DECODE/EXEC/MEM/WB with req/ready
// instruction and data memory ports that stall the FSM on wait-states.
module multicycle_datapath
    import rv_pkg::*;
#(
    parameter int PC_W       = 8,
    parameter int DATA_W     = 32,
    parameter int RF_ADDRESS = 5,
    parameter int DM_ADDRESS = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [PC_W-1:0]       imem_addr,
    input  logic                  imem_ready,
    input  logic [31:0]           imem_rdata,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DM_ADDRESS-1:0] dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic [PC_W-1:0]       pc,
    output logic [6:0]            opcode,
    output logic [2:0]            funct3,
    output logic [6:0]            funct7,
    output logic [DATA_W-1:0]     alu_result,
    output logic                  retire,
    output logic                  illegal,
    output state_t                dbg_state
);

    // Handshake: a request is raised only in FETCH/MEM and held with stable
    // address/data until ready is sampled high on a rising edge; ready seen
    // while no request is outstanding has no effect.

    state_t                state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [31:0]           ir_q, ir_d;
    logic [DATA_W-1:0]     a_q, a_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic [DATA_W-1:0]     imm_q, imm_d;
    logic [DATA_W-1:0]     alu_q, alu_d;
    logic [DATA_W-1:0]     mdr_q, mdr_d;
    logic                  illegal_q, illegal_d;
    logic [DATA_W-1:0]     rf_q [2**RF_ADDRESS];

    logic                  rf_we;
    logic [RF_ADDRESS-1:0] rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic [RF_ADDRESS-1:0] rs1_idx, rs2_idx, rd_idx;
    logic [PC_W-1:0]       pc_plus4, pc_plus_imm;
    alu_op_t               alu_op;
    logic [DATA_W-1:0]     alu_b, alu_y;
    logic                  alu_zero;
    logic                  taken;

    assign opcode      = ir_q[6:0];
    assign funct3      = ir_q[14:12];
    assign funct7      = ir_q[31:25];
    assign rd_idx      = ir_q[7 +: RF_ADDRESS];
    assign rs1_idx     = ir_q[15 +: RF_ADDRESS];
    assign rs2_idx     = ir_q[20 +: RF_ADDRESS];
    assign pc_plus4    = pc_q + PC_W'(4);
    assign pc_plus_imm = pc_q + imm_q[PC_W-1:0];
    assign taken       = funct3[0] ? !alu_zero : alu_zero;

    assign pc         = pc_q;
    assign imem_addr  = pc_q;
    assign dmem_addr  = alu_q[DM_ADDRESS-1:0];
    assign dmem_wdata = b_q;
    assign dmem_we    = (state_q == S_MEM) && (opcode == OP_STORE);
    assign alu_result = alu_q;
    assign illegal    = illegal_q;
    assign dbg_state  = state_q;

    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = imm_q;
        case (opcode)
            OP_R: begin
                alu_op = funct_op(funct3, funct7[5]);
                alu_b  = b_q;
            end
            OP_I:      alu_op = funct_op(funct3, 1'b0);
            OP_BRANCH: begin
                alu_op = ALU_SUB;
                alu_b  = b_q;
            end
            default: ;
        endcase
    end

    rv_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (alu_op),
        .a      (a_q),
        .b      (alu_b),
        .result (alu_y),
        .zero   (alu_zero)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        illegal_d = illegal_q;
        rf_we     = 1'b0;
        rf_waddr  = rd_idx;
        rf_wdata  = alu_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        retire    = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d = rf_q[rs1_idx];
                b_d = rf_q[rs2_idx];
                case (opcode)
                    OP_STORE:  imm_d = {{(DATA_W-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
                    OP_BRANCH: imm_d = {{(DATA_W-13){ir_q[31]}}, ir_q[31], ir_q[7],
                                        ir_q[30:25], ir_q[11:8], 1'b0};
                    OP_JAL:    imm_d = {{(DATA_W-21){ir_q[31]}}, ir_q[31], ir_q[19:12],
                                        ir_q[20], ir_q[30:21], 1'b0};
                    default:   imm_d = {{(DATA_W-12){ir_q[31]}}, ir_q[31:20]};
                endcase
                state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_d = alu_y;
                case (opcode)
                    OP_R, OP_I:         state_d = S_WB;
                    OP_LOAD, OP_STORE:  state_d = S_MEM;
                    OP_BRANCH: begin
                        pc_d    = taken ? pc_plus_imm : pc_plus4;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_JAL: begin
                        // Link value is the zero-extended return address.
                        alu_d   = DATA_W'(pc_plus4);
                        pc_d    = pc_plus_imm;
                        state_d = S_WB;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        pc_d      = pc_plus4;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_d    = pc_plus4;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = dmem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = (rd_idx != '0);
                rf_wdata = (opcode == OP_LOAD) ? mdr_q : alu_q;
                if (opcode != OP_JAL) begin
                    pc_d = pc_plus4;
                end
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Hold every handshake and the retire pulse low while reset is asserted.
        if (reset) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            retire   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            ir_q      <= NOP_INSN;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 2**RF_ADDRESS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            illegal_q <= illegal_d;
            if (rf_we) begin
                rf_q[rf_waddr] <= rf_wdata;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Randomised bench for multicycle_datapath: memory responders feed instructions
// and data with random wait-states; an ISA-level model predicts each retirement.
module tb_multicycle_datapath;
    import rv_pkg::*;

    localparam int PC_W = 8, DATA_W = 32, RF_ADDRESS = 5, DM_ADDRESS = 9;
    localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_XOR = 4, K_SLT = 5;
    localparam int K_ADDI = 6, K_ANDI = 7, K_ORI = 8, K_XORI = 9, K_SLTI = 10;
    localparam int K_LW = 11, K_SW = 12, K_BEQ = 13, K_BNE = 14, K_JAL = 15, K_ILL = 16;

    typedef struct {
        int kind; int rd; int rs1; int rs2; int imm; int iw; int dw;
    } insn_t;

    typedef struct {
        logic [7:0]  pc_next;
        logic        has_alu;
        logic [31:0] alu;
        logic        mem;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic        ill;
        int          lat;
    } exp_t;

    logic clk, reset;
    logic imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, illegal;
    logic [PC_W-1:0] imem_addr, pc;
    logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, alu_result;
    logic [DM_ADDRESS-1:0] dmem_addr;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    state_t dbg_state;

    multicycle_datapath #(.PC_W(PC_W), .DATA_W(DATA_W), .RF_ADDRESS(RF_ADDRESS),
                          .DM_ADDRESS(DM_ADDRESS)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .pc(pc), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .alu_result(alu_result), .retire(retire), .illegal(illegal),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    logic [31:0] regs [32];
    logic [31:0] ref_dm [128];
    logic [31:0] mem_dev [128];
    logic [7:0]  ref_pc;
    logic        ref_ill;
    exp_t        exp_q[$];
    insn_t       dir_q[$];
    int          cur_dw;

    int n_cmp = 0, n_fail = 0, n_ret = 0;
    logic timed_out = 1'b0;

    function automatic insn_t mk(int kind, int rd, int rs1, int rs2, int imm, int iw, int dw);
        insn_t x;
        x.kind = kind; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2; x.imm = imm; x.iw = iw; x.dw = dw;
        return x;
    endfunction

    function automatic logic [31:0] enc(insn_t x);
        logic [4:0] rd, rs1, rs2;
        logic [11:0] i12;
        logic [12:0] b13;
        logic [20:0] j21;
        logic [31:0] w;
        rd = 5'(x.rd); rs1 = 5'(x.rs1); rs2 = 5'(x.rs2);
        i12 = 12'(x.imm); b13 = 13'(x.imm); j21 = 21'(x.imm);
        case (x.kind)
            K_ADD:  w = {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_SUB:  w = {7'h20, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_AND:  w = {7'h00, rs2, rs1, 3'b111, rd, 7'b0110011};
            K_OR:   w = {7'h00, rs2, rs1, 3'b110, rd, 7'b0110011};
            K_XOR:  w = {7'h00, rs2, rs1, 3'b100, rd, 7'b0110011};
            K_SLT:  w = {7'h00, rs2, rs1, 3'b010, rd, 7'b0110011};
            K_ADDI: w = {i12, rs1, 3'b000, rd, 7'b0010011};
            K_ANDI: w = {i12, rs1, 3'b111, rd, 7'b0010011};
            K_ORI:  w = {i12, rs1, 3'b110, rd, 7'b0010011};
            K_XORI: w = {i12, rs1, 3'b100, rd, 7'b0010011};
            K_SLTI: w = {i12, rs1, 3'b010, rd, 7'b0010011};
            K_LW:   w = {i12, rs1, 3'b010, rd, 7'b0000011};
            K_SW:   w = {i12[11:5], rs2, rs1, 3'b010, i12[4:0], 7'b0100011};
            K_BEQ:  w = {b13[12], b13[10:5], rs2, rs1, 3'b000, b13[4:1], b13[11], 7'b1100011};
            K_BNE:  w = {b13[12], b13[10:5], rs2, rs1, 3'b001, b13[4:1], b13[11], 7'b1100011};
            K_JAL:  w = {j21[20], j21[10:1], j21[11], j21[19:12], rd, 7'b1101111};
            default: w = {25'h0, 7'(x.imm)};
        endcase
        return w;
    endfunction

    function automatic insn_t rand_insn();
        insn_t x;
        int r;
        int ill_ops[5] = '{'h7F, 'h37, 'h17, 'h00, 'h67};
        r = $urandom_range(0, 99);
        x = mk(K_ADD, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0,
               $urandom_range(0, 2), $urandom_range(0, 3));
        if (r < 30) x.kind = $urandom_range(K_ADD, K_SLT);
        else if (r < 55) begin x.kind = $urandom_range(K_ADDI, K_SLTI); x.imm = $urandom_range(0, 4095) - 2048; end
        else if (r < 68) begin x.kind = K_LW; x.imm = $urandom_range(0, 4095) - 2048; end
        else if (r < 80) begin x.kind = K_SW; x.imm = $urandom_range(0, 4095) - 2048; end
        else if (r < 88) begin x.kind = $urandom_range(K_BEQ, K_BNE); x.imm = ($urandom_range(0, 31) - 16) * 4; end
        else if (r < 94) begin x.kind = K_JAL; x.imm = ($urandom_range(0, 63) - 32) * 4; end
        else begin x.kind = K_ILL; x.imm = ill_ops[$urandom_range(0, 4)]; end
        return x;
    endfunction

    // Architectural effect of one instruction, from the ISA rules.
    task automatic model_exec(input insn_t x, output exp_t e);
        logic [31:0] a, b, im, res;
        logic wr;
        a = regs[x.rs1]; b = regs[x.rs2]; im = 32'(x.imm);
        res = '0; wr = 1'b0;
        e.pc_next = ref_pc + 8'd4; e.has_alu = 1'b0; e.alu = '0; e.mem = 1'b0;
        e.we = 1'b0; e.addr = '0; e.wdata = '0; e.lat = 4;
        case (x.kind)
            K_ADD:  res = a + b;
            K_SUB:  res = a - b;
            K_AND:  res = a & b;
            K_OR:   res = a | b;
            K_XOR:  res = a ^ b;
            K_SLT:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            K_ADDI: res = a + im;
            K_ANDI: res = a & im;
            K_ORI:  res = a | im;
            K_XORI: res = a ^ im;
            K_SLTI: res = ($signed(a) < $signed(im)) ? 32'd1 : 32'd0;
            default: ;
        endcase
        case (x.kind)
            K_LW: begin
                e.addr = 9'(a + im); res = ref_dm[e.addr[8:2]]; wr = 1'b1;
                e.mem = 1'b1; e.lat = 5 + x.dw;
            end
            K_SW: begin
                e.addr = 9'(a + im); ref_dm[e.addr[8:2]] = b;
                e.mem = 1'b1; e.we = 1'b1; e.wdata = b; e.lat = 4 + x.dw;
            end
            K_BEQ, K_BNE: begin
                if ((a == b) == (x.kind == K_BEQ)) e.pc_next = ref_pc + 8'(x.imm);
                e.lat = 3;
            end
            K_JAL: begin
                res = {24'h0, ref_pc + 8'd4}; e.pc_next = ref_pc + 8'(x.imm);
                wr = 1'b1; e.has_alu = 1'b1;
            end
            K_ILL: begin ref_ill = 1'b1; e.lat = 3; end
            default: begin wr = 1'b1; e.has_alu = 1'b1; end
        endcase
        e.alu = res;
        if (wr && x.rd != 0) regs[x.rd] = res;
        ref_pc = e.pc_next;
        e.ill = ref_ill;
        e.lat = e.lat + x.iw;
    endtask

    // ---------------- instruction memory driver ----------------
    logic i_busy;
    int i_left;
    logic [31:0] cur_word;
    always @(negedge clk) begin : imem_driver
        insn_t cur;
        exp_t e;
        if (reset) begin
            i_busy = 1'b0; imem_ready = 1'b0; imem_rdata = $urandom;
            for (int i = 0; i < 32; i++) regs[i] = '0;
            for (int i = 0; i < 128; i++) ref_dm[i] = mem_dev[i];
            ref_pc = '0; ref_ill = 1'b0;
        end else if (imem_req) begin
            if (!i_busy) begin
                cur = (dir_q.size() > 0) ? dir_q.pop_front() : rand_insn();
                model_exec(cur, e);
                exp_q.push_back(e);
                cur_word = enc(cur); i_left = cur.iw; cur_dw = cur.dw; i_busy = 1'b1;
            end
            if (i_left == 0) begin
                imem_ready = 1'b1; imem_rdata = cur_word; i_busy = 1'b0;
            end else begin
                i_left--; imem_ready = 1'b0; imem_rdata = $urandom;
            end
        end else begin
            imem_ready = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
        end
    end

    // ---------------- data memory driver ----------------
    logic d_busy;
    int d_left;
    always @(negedge clk) begin : dmem_driver
        if (reset) begin
            d_busy = 1'b0; dmem_ready = 1'b0; dmem_rdata = $urandom;
        end else if (dmem_req) begin
            if (!d_busy) begin d_left = cur_dw; d_busy = 1'b1; end
            if (d_left == 0) begin
                dmem_ready = 1'b1; d_busy = 1'b0;
                if (dmem_we) begin
                    mem_dev[dmem_addr[8:2]] = dmem_wdata; dmem_rdata = $urandom;
                end else dmem_rdata = mem_dev[dmem_addr[8:2]];
            end else begin
                d_left--; dmem_ready = 1'b0; dmem_rdata = $urandom;
            end
        end else begin
            dmem_ready = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
        end
    end

    // ---------------- scoreboard monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    int cnt = 0, last = 0;
    logic pend = 1'b0, rst_prev = 1'b0, to_seen = 1'b0;
    exp_t pend_e;
    always @(negedge clk) begin : monitor
        exp_t e;
        #1;
        if (timed_out != to_seen) begin
            chk("wait_bound", 32'(timed_out), 32'd0); to_seen = timed_out;
        end
        if (reset) begin
            if (rst_prev) begin
                chk("rst_pc", 32'(pc), 0);             chk("rst_imem_addr", 32'(imem_addr), 0);
                chk("rst_imem_req", 32'(imem_req), 0); chk("rst_dmem_req", 32'(dmem_req), 0);
                chk("rst_dmem_we", 32'(dmem_we), 0);   chk("rst_dmem_addr", 32'(dmem_addr), 0);
                chk("rst_dmem_wdata", dmem_wdata, 0);  chk("rst_retire", 32'(retire), 0);
                chk("rst_illegal", 32'(illegal), 0);   chk("rst_alu_result", alu_result, 0);
                chk("rst_opcode", 32'(opcode), 32'h13); chk("rst_funct3", 32'(funct3), 0);
                chk("rst_funct7", 32'(funct7), 0);     chk("rst_state", 32'(dbg_state), 32'(S_FETCH));
            end
            exp_q.delete(); pend = 1'b0; cnt = 0; last = 0;
        end else begin
            cnt++;
            if (rst_prev) begin
                chk("post_rst_imem_req", 32'(imem_req), 1);
                chk("post_rst_imem_addr", 32'(imem_addr), 0);
                chk("post_rst_state", 32'(dbg_state), 32'(S_FETCH));
            end
            if (pend) begin
                chk("pc_after_retire", 32'(pc), 32'(pend_e.pc_next));
                chk("illegal_flag", 32'(illegal), 32'(pend_e.ill));
                pend = 1'b0;
            end
            if (dmem_req) begin
                chk("dmem_req_has_expect", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("dmem_req_expected", 32'(exp_q[0].mem), 1);
                    chk("dmem_we", 32'(dmem_we), 32'(exp_q[0].we));
                    chk("dmem_addr", 32'(dmem_addr), 32'(exp_q[0].addr));
                    if (exp_q[0].we) chk("dmem_wdata", dmem_wdata, exp_q[0].wdata);
                end
            end
            if (retire) begin
                chk("retire_has_expect", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("latency", 32'(cnt - last), 32'(e.lat));
                    if (e.has_alu) chk("alu_result", alu_result, e.alu);
                    pend = 1'b1; pend_e = e; last = cnt; n_ret++;
                end
            end
        end
        rst_prev = reset;
    end

    // ---------------- stimulus sequence ----------------
    initial begin
        int target;
        logic hit;
        for (int i = 0; i < 128; i++) mem_dev[i] = $urandom;
        // Directed prologue: zero-wait ALU chain, stalled store/load, branches,
        // JAL with PC wrap, x0 discard and an illegal opcode.
        dir_q.push_back(mk(K_ADDI, 1, 0, 0, 5, 0, 0));
        dir_q.push_back(mk(K_ADDI, 2, 0, 0, 7, 0, 0));
        dir_q.push_back(mk(K_ADD, 3, 1, 2, 0, 0, 0));
        dir_q.push_back(mk(K_SW, 0, 0, 3, 0, 0, 3));
        dir_q.push_back(mk(K_LW, 4, 0, 0, 0, 0, 3));
        dir_q.push_back(mk(K_ADDI, 0, 0, 0, 9, 0, 0));
        dir_q.push_back(mk(K_ADD, 6, 0, 4, 0, 0, 0));
        dir_q.push_back(mk(K_ADD, 7, 0, 0, 0, 0, 0));
        dir_q.push_back(mk(K_BEQ, 0, 1, 1, 16, 0, 0));
        dir_q.push_back(mk(K_BNE, 0, 1, 1, 16, 0, 0));
        dir_q.push_back(mk(K_JAL, 5, 0, 0, -8, 0, 0));
        dir_q.push_back(mk(K_JAL, 6, 0, 0, -48, 0, 0));
        dir_q.push_back(mk(K_ILL, 0, 0, 0, 'h7F, 0, 0));
        dir_q.push_back(mk(K_SW, 0, 0, 6, 4, 1, 0));

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        target = 250;
        for (int c = 0; c < 20000 && n_ret < target; c++) @(negedge clk);
        if (n_ret < target) timed_out = 1'b1;

        hit = 1'b0;
        for (int c = 0; c < 2000 && !hit; c++) begin
            @(negedge clk);
            #3;
            if (dmem_req) hit = 1'b1;
        end
        if (!hit) timed_out = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        target = n_ret + 60;
        for (int c = 0; c < 20000 && n_ret < target; c++) @(negedge clk);
        if (n_ret < target) timed_out = 1'b1;

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
